// File: rtl/rf_write_port_arbiter.sv
// Shares the register file write port between the pipeline writeback path and a
// buffered long-latency result stream, with a starvation stall so buffered results drain.
module rf_write_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int BUF_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pipe_wb_en,
  input  logic [ADDR_WIDTH-1:0]        pipe_wb_rd,
  input  logic [DATA_WIDTH-1:0]        pipe_wb_data,
  input  logic                         ml_valid,
  input  logic [ADDR_WIDTH-1:0]        ml_rd,
  input  logic [DATA_WIDTH-1:0]        ml_data,
  output logic                         ml_ready,
  output logic                         rf_we,
  output logic [ADDR_WIDTH-1:0]        rf_waddr,
  output logic [DATA_WIDTH-1:0]        rf_wdata,
  output logic                         pipe_stall,
  output logic [$clog2(BUF_DEPTH):0]   buf_count
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(BUF_DEPTH);
  localparam logic [SW-1:0] STARVE_C = SW'(STARVE_LIMIT);

  logic [ADDR_WIDTH-1:0] rd_mem   [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [BUF_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [SW-1:0]         starve_cnt;
  logic                  pipe_live;
  logic                  head_grant;
  logic                  enq;

  // Acceptance depends only on registered occupancy, so a full buffer never passes through.
  assign ml_ready   = ~rst & (count < DEPTH_C);
  assign pipe_stall = ~rst & (starve_cnt == STARVE_C);
  assign buf_count  = rst ? '0 : count;

  // Writes to x0 are handshaken but discarded.
  assign enq        = ml_valid & ml_ready & (ml_rd != '0);
  assign pipe_live  = ~rst & pipe_wb_en & (pipe_wb_rd != '0) & ~pipe_stall;
  assign head_grant = ~rst & ~pipe_live & (count != '0);

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (pipe_live) begin
      rf_we    = 1'b1;
      rf_waddr = pipe_wb_rd;
      rf_wdata = pipe_wb_data;
    end else if (head_grant) begin
      rf_we    = 1'b1;
      rf_waddr = rd_mem[rd_ptr];
      rf_wdata = data_mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      if (enq)        wr_ptr <= wr_ptr + PW'(1);
      if (head_grant) rd_ptr <= rd_ptr + PW'(1);
      case ({enq, head_grant})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (count == '0 || head_grant)
        starve_cnt <= '0;
      else if (starve_cnt != STARVE_C)
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Payload storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (enq) begin
      rd_mem[wr_ptr]   <= ml_rd;
      data_mem[wr_ptr] <= ml_data;
    end
  end

endmodule

// File: doc/rf_write_port_arbiter.md
Name: rf_write_port_arbiter

Overview:
- Owns the single register file write port and shares it between two requesters.
- Requester 1: the pipeline writeback path, i.e. the MEM/WB RegWrite, rd and selected writeback data.
- Requester 2: a long-latency result source (multiply/divide unit) that uses a valid/ready handshake.
- Long-latency results are buffered in a small FIFO. The pipeline normally has priority; a starvation counter forces a one-cycle pipeline stall so buffered results always drain.

Parameters:
- DATA_WIDTH, 32, register data width.
- ADDR_WIDTH, 5, register address width.
- BUF_DEPTH, 2, long-latency result FIFO entries; power of two, >=2.
- STARVE_LIMIT, 4, number of consecutive denied cycles for the FIFO head before the pipeline is stalled; >=1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pipe_wb_en  in  1  pipeline write request (MEM/WB RegWrite).
- pipe_wb_rd  in  ADDR_WIDTH  pipeline destination register.
- pipe_wb_data  in  DATA_WIDTH  pipeline writeback data.
- ml_valid  in  1  long-latency result valid.
- ml_rd  in  ADDR_WIDTH  long-latency destination register.
- ml_data  in  DATA_WIDTH  long-latency result.
- ml_ready  out  1  FIFO can accept a result.
- rf_we  out  1  register file write enable.
- rf_waddr  out  ADDR_WIDTH  register file write address.
- rf_wdata  out  DATA_WIDTH  register file write data.
- pipe_stall  out  1  freezes MEM/WB and everything upstream for this cycle.
- buf_count  out  $clog2(BUF_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset:
  - While rst=1: FIFO pointers=0, buf_count=0, starve_cnt=0; rf_we=0, ml_ready=0, pipe_stall=0.
  - Buffered entries are discarded when rst is asserted mid-operation.
- Acceptance:
  - ml_ready = ~rst & (buf_count < BUF_DEPTH), derived from registered state only; no combinational path from ml_valid.
  - When full, ml_ready=0 even if a dequeue occurs in the same cycle (no pass-through).
  - A handshake (ml_valid & ml_ready) with ml_rd=0 is accepted and dropped: not enqueued, buf_count unchanged.
- Latency: no bypass path; an accepted result reaches rf_we no earlier than the cycle after acceptance.
- Grant (combinational each cycle, from current state and inputs):
  - pipe_live = pipe_wb_en & (pipe_wb_rd != 0) & ~pipe_stall.
  - If pipe_live: rf_we=1, rf_waddr=pipe_wb_rd, rf_wdata=pipe_wb_data.
  - Else if buf_count>0: rf_we=1 with the FIFO head; the head dequeues at the clock edge.
  - Else rf_we=0; rf_waddr and rf_wdata are don't-care but held at 0.
  - A pipeline request with rd=0 never occupies the port; the FIFO head may use that cycle.
- Starvation:
  - starve_cnt increments (saturating at STARVE_LIMIT) each cycle buf_count>0 and the head is not granted.
  - starve_cnt clears to 0 when the head is granted or the FIFO is empty.
  - pipe_stall = (starve_cnt == STARVE_LIMIT); registered-state-derived, asserted for exactly one cycle.
  - While pipe_stall=1, pipe inputs are ignored and the head is granted.
  - The pipeline holds MEM/WB during the stall and presents the same write again the next cycle; that write is not lost.
  - Bound: a FIFO head is written within STARVE_LIMIT+1 cycles of reaching the head.
- Simultaneous enqueue and dequeue: buf_count unchanged; FIFO order preserved; pointers wrap modulo BUF_DEPTH.
- Hazards: WAW between a buffered result and a pipeline write to the same rd is excluded by the ID-stage scoreboard. It is not checked here.

Test Plan:
- Reset: hold rst for 2 cycles with ml_valid=1 and pipe_wb_en=1 -> rf_we=0, ml_ready=0, buf_count=0, pipe_stall=0; after release ml_ready=1.
- Pipe-only path:
  - pipe_wb_en=1, rd=5, data=0xDEADBEEF -> same cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
  - rd=0 -> rf_we=0.
- Long-latency path: pipe idle, push rd=7, data=0x00001234 at cycle t -> buf_count=1 at t+1 with rf_we=1, waddr=7; buf_count=0 at t+2.
- Starvation (STARVE_LIMIT=4):
  - Stimulus: push rd=9 while the pipeline writes rd=3 every cycle.
  - Response: 4 consecutive rd=3 writes, then pipe_stall=1 for one cycle with rf_waddr=9, then the held rd=3 write reappears.
- Full buffer (BUF_DEPTH=2): pipeline busy, push 2 results -> buf_count=2, ml_ready=0, third ml_valid held; the cycle after the first dequeue ml_ready=1.
- x0 push and reset mid-operation:
  - ml_rd=0 handshake -> buf_count unchanged, no rf write.
  - With 2 buffered entries, assert rst for 1 cycle -> buf_count=0 and no rf_we afterwards.
